wb_j1_core_p: RTL and testbench

Parametrised successor to the team's J1 stack CPU with a Wishbone master interface. It executes 16-bit J1 instructions fetched combinationally from an external instruction memory via pc_o. It keeps data and return stacks of configurable depth with overflow/underflow trapping. Data-memory accesses go through a registered Wishbone classic master FSM with a timeout; a one-cycle I/O page bypasses the bus for UART-style peripherals.

---
 rtl/j1_pkg.sv | 55 +++++
 rtl/j1_stack.sv | 75 +++++++
 rtl/wb_j1_core_p.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_wb_j1_core_p.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/j1_pkg.sv
// ---------------------------------------------------------------------------
// j1_pkg
// Shared definitions for the wb_j1_core_p stack CPU:
//   - bit positions of the fields inside a 16-bit J1 instruction
//   - instruction class and ALU opcode encodings
//   - control FSM state encoding
// No ports; imported by j1_stack and wb_j1_core_p.
// ---------------------------------------------------------------------------
package j1_pkg;

  // Instruction field positions
  localparam int LIT_BIT = 15;   // 1 = literal, payload in [14:0]
  localparam int CLS_LO  = 13;   // [14:13] instruction class
  localparam int TGT_W   = 13;   // [12:0] jump/branch/call target
  localparam int RPC_BIT = 12;   // ALU: R -> PC
  localparam int OP_LO   = 8;    // ALU: [11:8] operation
  localparam int TN_BIT  = 7;    // ALU: T -> N
  localparam int TR_BIT  = 6;    // ALU: T -> R
  localparam int NT_BIT  = 5;    // ALU: N -> [T] (store)
  localparam int RD_LO   = 2;    // ALU: [3:2] return-stack delta
  localparam int DD_LO   = 0;    // ALU: [1:0] data-stack delta

  typedef enum logic [1:0] {
    CLS_JMP  = 2'b00,
    CLS_ZBR  = 2'b01,
    CLS_CALL = 2'b10,
    CLS_ALU  = 2'b11
  } insn_class_e;

  typedef enum logic [3:0] {
    OP_T     = 4'd0,
    OP_N     = 4'd1,
    OP_ADD   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_INV   = 4'd6,
    OP_EQ    = 4'd7,
    OP_LTS   = 4'd8,
    OP_SHR   = 4'd9,
    OP_DEC   = 4'd10,
    OP_R     = 4'd11,
    OP_MEM   = 4'd12,
    OP_SHL   = 4'd13,
    OP_DEPTH = 4'd14,
    OP_LTU   = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_MEM  = 2'd1,
    S_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/j1_stack.sv
// ---------------------------------------------------------------------------
// j1_stack
// One J1 stack (data or return): distributed RAM with synchronous write and
// asynchronous read, an occupancy counter of AW+1 bits, and fault detection.
// The entry below the top-of-stack register lives at RAM[count-1].
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears the counter)
//   i_commit   instruction commits this cycle
//   i_delta    2-bit signed occupancy change requested by the instruction
//   i_we       write i_wdata into the new top RAM slot on commit
//   i_wdata    value to write
//   o_top      RAM entry at the top (0 when the stack is empty)
//   o_count    current occupancy
//   o_fault    requested delta would underflow or overflow the stack
// ---------------------------------------------------------------------------
module j1_stack
  import j1_pkg::*;
#(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_commit,
  input  logic [1:0]    i_delta,
  input  logic          i_we,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_top,
  output logic [AW:0]   o_count,
  output logic          o_fault
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW:0]   r_count;
  logic [AW+1:0] w_deltaExt;
  logic [AW+1:0] w_newCount;
  logic [AW-1:0] w_wrAddr;
  logic [AW-1:0] w_topAddr;
  logic          w_underflow;
  logic          w_overflow;

  // The new occupancy is computed one bit wider than the counter so that a
  // pop below zero shows up as a set sign bit and a push past full as a
  // value above DEPTH. A zero delta can never fault.
  assign w_deltaExt  = {{AW{i_delta[1]}}, i_delta};
  assign w_newCount  = {1'b0, r_count} + w_deltaExt;
  assign w_underflow = w_newCount[AW+1];
  assign w_overflow  = !w_newCount[AW+1] && (w_newCount[AW:0] > (AW+1)'(DEPTH));
  assign o_fault     = w_underflow | w_overflow;

  // The written slot is always the one that becomes the top after the delta.
  assign w_wrAddr  = r_count[AW-1:0] + w_deltaExt[AW-1:0] - AW'(1);
  assign w_topAddr = r_count[AW-1:0] - AW'(1);
  assign o_top     = (r_count == '0) ? '0 : r_mem[w_topAddr];
  assign o_count   = r_count;

  // RAM write port: only committed, non-faulting instructions touch storage.
  always_ff @(posedge clk) begin
    if (i_commit && i_we && !o_fault) begin
      r_mem[w_wrAddr] <= i_wdata;
    end
  end

  // Occupancy counter follows the committed delta.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_commit && !o_fault) begin
      r_count <= w_newCount[AW:0];
    end
  end

endmodule

// File: rtl/wb_j1_core_p.sv
// ---------------------------------------------------------------------------
// wb_j1_core_p
// Parametrised J1 stack CPU with a registered Wishbone classic master for
// data memory and a single-cycle I/O page for byte-wide peripherals.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   inst_i / pc_o         combinational instruction fetch
//   cpu_num               constant CPU_ID
//   cyc_o stb_o we_o      Wishbone master controls (registered)
//   adr_o dat_o / dat_i   Wishbone address, write data / read data
//   ack_i                 Wishbone acknowledge
//   io_dat_i / io_dat_o   I/O page read data / write data (N[7:0])
//   io_adr_o              I/O register select (T[0])
//   io_rd_o io_wr_o       one-cycle I/O strobes
//   halt_i / halted_o     stall request / core is in HALT
//   fault_o               sticky stack faults {return, data}
//   bus_err_o             sticky Wishbone timeout
// ---------------------------------------------------------------------------
module wb_j1_core_p
  import j1_pkg::*;
#(
  parameter int         DATA_W  = 32,
  parameter int         PC_W    = 13,
  parameter int         DSTK_AW = 5,
  parameter int         RSTK_AW = 5,
  parameter int         CPU_ID  = 0,
  parameter logic [3:0] IO_PAGE = 4'hF,
  parameter int         TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       inst_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [7:0]        cpu_num,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [DATA_W-1:0] adr_o,
  output logic [DATA_W-1:0] dat_o,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              ack_i,
  input  logic [7:0]        io_dat_i,
  output logic [7:0]        io_dat_o,
  output logic              io_adr_o,
  output logic              io_rd_o,
  output logic              io_wr_o,
  input  logic              halt_i,
  output logic              halted_o,
  output logic [1:0]        fault_o,
  output logic              bus_err_o
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_e              r_state;
  state_e              w_nextState;
  logic [PC_W-1:0]     r_pc;
  logic [DATA_W-1:0]   r_t;
  logic [1:0]          r_fault;
  logic                r_cyc;
  logic                r_stb;
  logic                r_we;
  logic [DATA_W-1:0]   r_adr;
  logic [DATA_W-1:0]   r_dat;
  logic [15:0]         r_wait;
  logic                r_busErr;

  logic                w_isLit;
  insn_class_e         w_class;
  alu_op_e             w_op;
  logic                w_isAlu;
  logic                w_isLoad;
  logic                w_isStore;
  logic                w_isMem;
  logic                w_ioPage;
  logic [PC_W-1:0]     w_pcPlus1;
  logic [PC_W-1:0]     w_target;
  logic [DATA_W-1:0]   w_retAddr;
  logic [DATA_W-1:0]   w_n;
  logic [DATA_W-1:0]   w_r;
  logic [DSTK_AW:0]    w_dCount;
  logic [RSTK_AW:0]    w_rCount;
  logic                w_dFault;
  logic                w_rFault;
  logic [DATA_W-1:0]   w_rdData;
  logic [DATA_W-1:0]   w_aluResult;
  logic [1:0]          w_dDelta;
  logic                w_dWe;
  logic [1:0]          w_rDelta;
  logic                w_rWe;
  logic [DATA_W-1:0]   w_rWdata;
  logic [PC_W-1:0]     w_nextPc;
  logic [DATA_W-1:0]   w_nextT;
  logic                w_commit;
  logic                w_issue;
  logic                w_busEnd;
  logic                w_timeout;
  logic [1:0]          w_setFault;

  // Instruction decode
  assign w_isLit   = inst_i[LIT_BIT];
  assign w_class   = insn_class_e'(inst_i[CLS_LO +: 2]);
  assign w_op      = alu_op_e'(inst_i[OP_LO +: 4]);
  assign w_isAlu   = !w_isLit && (w_class == CLS_ALU);
  assign w_isLoad  = w_isAlu && (w_op == OP_MEM);
  assign w_isStore = w_isAlu && inst_i[NT_BIT];
  assign w_isMem   = w_isLoad || w_isStore;
  assign w_ioPage  = (r_t[DATA_W-1 -: 4] == IO_PAGE);

  assign w_pcPlus1 = r_pc + PC_W'(1);
  assign w_target  = PC_W'(inst_i[TGT_W-1:0]);
  assign w_retAddr = DATA_W'({w_pcPlus1, 2'b00});

  // Memory read data: the bus in MEM (zero on a timeout), else the I/O page.
  assign w_rdData = (r_state == S_MEM) ? (ack_i ? dat_i : '0)
                                       : {{(DATA_W-8){1'b0}}, io_dat_i};

  j1_stack #(.W(DATA_W), .AW(DSTK_AW)) u_dstack (
    .clk      (clk),
    .rst      (rst),
    .i_commit (w_commit),
    .i_delta  (w_dDelta),
    .i_we     (w_dWe),
    .i_wdata  (r_t),
    .o_top    (w_n),
    .o_count  (w_dCount),
    .o_fault  (w_dFault)
  );

  j1_stack #(.W(DATA_W), .AW(RSTK_AW)) u_rstack (
    .clk      (clk),
    .rst      (rst),
    .i_commit (w_commit),
    .i_delta  (w_rDelta),
    .i_we     (w_rWe),
    .i_wdata  (w_rWdata),
    .o_top    (w_r),
    .o_count  (w_rCount),
    .o_fault  (w_rFault)
  );

  // ALU: comparisons produce all-ones / all-zeros words.
  always_comb begin
    w_aluResult = r_t;
    case (w_op)
      OP_T:     w_aluResult = r_t;
      OP_N:     w_aluResult = w_n;
      OP_ADD:   w_aluResult = r_t + w_n;
      OP_AND:   w_aluResult = r_t & w_n;
      OP_OR:    w_aluResult = r_t | w_n;
      OP_XOR:   w_aluResult = r_t ^ w_n;
      OP_INV:   w_aluResult = ~r_t;
      OP_EQ:    w_aluResult = {DATA_W{w_n == r_t}};
      OP_LTS:   w_aluResult = {DATA_W{$signed(w_n) < $signed(r_t)}};
      OP_SHR:   w_aluResult = w_n >> r_t;
      OP_DEC:   w_aluResult = r_t - DATA_W'(1);
      OP_R:     w_aluResult = w_r;
      OP_MEM:   w_aluResult = w_rdData;
      OP_SHL:   w_aluResult = w_n << r_t;
      OP_DEPTH: w_aluResult = DATA_W'({w_rCount, w_dCount});
      OP_LTU:   w_aluResult = {DATA_W{w_n < r_t}};
      default:  w_aluResult = r_t;
    endcase
  end

  // Per-class effects: stack deltas/writes, next PC and next T. These are
  // only applied when the FSM commits the instruction.
  always_comb begin
    w_dDelta = 2'b00;
    w_dWe    = 1'b0;
    w_rDelta = 2'b00;
    w_rWe    = 1'b0;
    w_rWdata = r_t;
    w_nextPc = w_pcPlus1;
    w_nextT  = r_t;
    if (w_isLit) begin
      w_dDelta = 2'b01;
      w_dWe    = 1'b1;
      w_nextT  = DATA_W'(inst_i[LIT_BIT-1:0]);
    end else begin
      case (w_class)
        CLS_JMP: w_nextPc = w_target;
        CLS_ZBR: begin
          w_dDelta = 2'b11;
          w_nextT  = w_n;
          if (r_t == '0) w_nextPc = w_target;
        end
        CLS_CALL: begin
          w_rDelta = 2'b01;
          w_rWe    = 1'b1;
          w_rWdata = w_retAddr;
          w_nextPc = w_target;
        end
        CLS_ALU: begin
          w_dDelta = inst_i[DD_LO +: 2];
          w_dWe    = inst_i[TN_BIT];
          w_rDelta = inst_i[RD_LO +: 2];
          w_rWe    = inst_i[TR_BIT];
          w_nextT  = w_aluResult;
          if (inst_i[RPC_BIT]) w_nextPc = w_r[PC_W+1:2];
        end
        default: w_nextPc = w_pcPlus1;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_nextState;
  end

  // FSM next state and control strobes. halt_i and stack faults are checked
  // before an instruction starts; a bus access always runs to ack or timeout.
  always_comb begin
    w_nextState = r_state;
    w_commit    = 1'b0;
    w_issue     = 1'b0;
    w_busEnd    = 1'b0;
    w_timeout   = 1'b0;
    w_setFault  = 2'b00;
    case (r_state)
      S_RUN: begin
        if (halt_i) begin
          w_nextState = S_HALT;
        end else if (w_dFault || w_rFault) begin
          w_setFault  = {w_rFault, w_dFault};
          w_nextState = S_HALT;
        end else if (w_isMem && !w_ioPage) begin
          w_nextState = S_MEM;
        end else begin
          w_commit = 1'b1;
        end
      end
      S_MEM: begin
        if (!r_cyc) begin
          w_issue = 1'b1;
        end else if (ack_i) begin
          w_busEnd    = 1'b1;
          w_commit    = 1'b1;
          w_nextState = S_RUN;
        end else if (r_wait == WAIT_LAST) begin
          w_busEnd    = 1'b1;
          w_timeout   = 1'b1;
          w_commit    = 1'b1;
          w_nextState = S_RUN;
        end
      end
      S_HALT: begin
        if (!halt_i && (r_fault == 2'b00)) w_nextState = S_RUN;
      end
      default: w_nextState = S_RUN;
    endcase
  end

  // Architectural state: PC and T change only on commit; faults are sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= '0;
      r_t     <= '0;
      r_fault <= 2'b00;
    end else begin
      if (w_commit) begin
        r_pc <= w_nextPc;
        r_t  <= w_nextT;
      end
      r_fault <= r_fault | w_setFault;
    end
  end

  // Wishbone master registers and wait-state counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_dat    <= '0;
      r_wait   <= '0;
      r_busErr <= 1'b0;
    end else if (w_issue) begin
      r_cyc  <= 1'b1;
      r_stb  <= 1'b1;
      r_we   <= w_isStore;
      r_adr  <= r_t;
      r_dat  <= w_n;
      r_wait <= '0;
    end else if (w_busEnd) begin
      r_cyc <= 1'b0;
      r_stb <= 1'b0;
      r_we  <= 1'b0;
      if (w_timeout) r_busErr <= 1'b1;
    end else if (r_cyc) begin
      r_wait <= r_wait + 16'd1;
    end
  end

  assign pc_o      = r_pc;
  assign cpu_num   = 8'(CPU_ID);
  assign cyc_o     = r_cyc;
  assign stb_o     = r_stb;
  assign we_o      = r_we;
  assign adr_o     = r_adr;
  assign dat_o     = r_dat;
  assign io_dat_o  = w_n[7:0];
  assign io_adr_o  = r_t[0];
  assign io_rd_o   = (r_state == S_RUN) && w_commit && w_isLoad && w_ioPage;
  assign io_wr_o   = (r_state == S_RUN) && w_commit && w_isStore && w_ioPage;
  assign halted_o  = (r_state == S_HALT);
  assign fault_o   = r_fault;
  assign bus_err_o = r_busErr;

endmodule

// File: tb/tb_wb_j1_core_p.sv
// ---------------------------------------------------------------------------
// tb_wb_j1_core_p
// Directed bench for wb_j1_core_p: small programs in a behavioural
// instruction ROM, hand-driven Wishbone/I/O responses, and hand-computed
// expected values checked with immediate assertions.
// ---------------------------------------------------------------------------
module tb_wb_j1_core_p;

  localparam int DATA_W = 32;
  localparam int PC_W   = 13;

  logic              clk;
  logic              rst;
  logic [15:0]       inst_i;
  logic [PC_W-1:0]   pc_o;
  logic [7:0]        cpu_num;
  logic              cyc_o;
  logic              stb_o;
  logic              we_o;
  logic [DATA_W-1:0] adr_o;
  logic [DATA_W-1:0] dat_o;
  logic [DATA_W-1:0] dat_i;
  logic              ack_i;
  logic [7:0]        io_dat_i;
  logic [7:0]        io_dat_o;
  logic              io_adr_o;
  logic              io_rd_o;
  logic              io_wr_o;
  logic              halt_i;
  logic              halted_o;
  logic [1:0]        fault_o;
  logic              bus_err_o;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] imem [0:(1<<PC_W)-1];

  assign inst_i = imem[pc_o];

  wb_j1_core_p #(
    .DATA_W  (DATA_W),
    .PC_W    (PC_W),
    .DSTK_AW (5),
    .RSTK_AW (5),
    .CPU_ID  (3),
    .IO_PAGE (4'hF),
    .TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_i    (inst_i),
    .pc_o      (pc_o),
    .cpu_num   (cpu_num),
    .cyc_o     (cyc_o),
    .stb_o     (stb_o),
    .we_o      (we_o),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .dat_i     (dat_i),
    .ack_i     (ack_i),
    .io_dat_i  (io_dat_i),
    .io_dat_o  (io_dat_o),
    .io_adr_o  (io_adr_o),
    .io_rd_o   (io_rd_o),
    .io_wr_o   (io_wr_o),
    .halt_i    (halt_i),
    .halted_o  (halted_o),
    .fault_o   (fault_o),
    .bus_err_o (bus_err_o)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and land 1 unit after the last one.
  task automatic stepCycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive the slave-side inputs, then let combinational paths settle.
  task automatic applyStimulus(input logic halt, input logic ack,
                               input logic [31:0] rdData, input logic [7:0] ioData);
    halt_i   = halt;
    ack_i    = ack;
    dat_i    = rdData;
    io_dat_i = ioData;
    #1;
  endtask

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Hold reset for two edges with a blank ROM; caller loads a program next.
  task automatic resetCore();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 8'h00);
    for (int i = 0; i < (1 << PC_W); i++) imem[i] = 16'h0000;
    stepCycle(2);
  endtask

  task automatic releaseReset();
    rst = 1'b0;
    #1;
  endtask

  // Directed sequence; encodings: LIT 8000|n, JMP 0000|t, CALL 4000|t,
  // ALU 6000|rpc<<12|op<<8|tn<<7|tr<<6|nt<<5|rd<<2|dd.
  initial begin
    $display("[TB] start");

    // Reset state
    resetCore();
    checkOutput("rst_pc", pc_o, 0);
    checkOutput("rst_T", dut.r_t, 0);
    checkOutput("rst_cyc", cyc_o, 0);
    checkOutput("rst_stb", stb_o, 0);
    checkOutput("rst_we", we_o, 0);
    checkOutput("rst_adr", adr_o, 0);
    checkOutput("rst_dat", dat_o, 0);
    checkOutput("rst_io", {io_rd_o, io_wr_o, io_adr_o}, 0);
    checkOutput("rst_iodat", io_dat_o, 0);
    checkOutput("rst_fault", fault_o, 0);
    checkOutput("rst_buserr", bus_err_o, 0);
    checkOutput("rst_halted", halted_o, 0);
    checkOutput("cpu_num", cpu_num, 3);

    // LIT 5, LIT 3, T+N d-1
    imem[0] = 16'h8005;
    imem[1] = 16'h8003;
    imem[2] = 16'h6203;
    imem[3] = 16'h0003;
    releaseReset();
    stepCycle(3);
    checkOutput("t1_T", dut.r_t, 32'd8);
    checkOutput("t1_depth", dut.u_dstack.r_count, 1);
    checkOutput("t1_pc", pc_o, 3);

    // Bus store with 3 wait states, then load with zero wait states
    resetCore();
    imem[0] = 16'h8100;
    imem[1] = 16'h8200;
    imem[2] = 16'h6020;
    imem[3] = 16'h6C00;
    imem[4] = 16'h0004;
    releaseReset();
    stepCycle(3);
    checkOutput("t2_mem_pc_hold", pc_o, 2);
    checkOutput("t2_mem_cyc0", cyc_o, 0);
    stepCycle(1);
    checkOutput("t2_cyc_c1", {cyc_o, stb_o, we_o}, 3'b111);
    checkOutput("t2_adr", adr_o, 32'h200);
    checkOutput("t2_dat", dat_o, 32'h100);
    stepCycle(1);
    checkOutput("t2_cyc_c2", cyc_o, 1);
    stepCycle(1);
    checkOutput("t2_cyc_c3", cyc_o, 1);
    stepCycle(1);
    checkOutput("t2_cyc_c4", cyc_o, 1);
    checkOutput("t2_pc_wait", pc_o, 2);
    applyStimulus(1'b0, 1'b1, 32'h0, 8'h00);
    stepCycle(1);
    applyStimulus(1'b0, 1'b0, 32'h0, 8'h00);
    checkOutput("t2_cyc_drop", {cyc_o, stb_o}, 2'b00);
    checkOutput("t2_pc_after_st", pc_o, 3);
    stepCycle(2);
    checkOutput("t2_ld_we", we_o, 0);
    checkOutput("t2_ld_cyc", cyc_o, 1);
    checkOutput("t2_ld_adr", adr_o, 32'h200);
    checkOutput("t2_T_hold", dut.r_t, 32'h200);
    applyStimulus(1'b0, 1'b1, 32'h0000ABCD, 8'h00);
    stepCycle(1);
    applyStimulus(1'b0, 1'b0, 32'h0, 8'h00);
    checkOutput("t2_ld_T", dut.r_t, 32'h0000ABCD);
    checkOutput("t2_ld_pc", pc_o, 4);
    checkOutput("t2_ld_cyc0", cyc_o, 0);

    // I/O page load: build 0xF0000001 then @
    resetCore();
    imem[0] = 16'hF800;
    imem[1] = 16'h8011;
    imem[2] = 16'h6D03;
    imem[3] = 16'h8001;
    imem[4] = 16'h6403;
    imem[5] = 16'h6C00;
    imem[6] = 16'h0006;
    releaseReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 8'h41);
    stepCycle(5);
    checkOutput("t3_T_io", dut.r_t, 32'hF0000001);
    checkOutput("t3_io_rd", io_rd_o, 1);
    checkOutput("t3_io_wr", io_wr_o, 0);
    checkOutput("t3_io_adr", io_adr_o, 1);
    stepCycle(1);
    checkOutput("t3_T", dut.r_t, 32'h41);
    checkOutput("t3_io_rd_end", io_rd_o, 0);
    checkOutput("t3_cyc", cyc_o, 0);
    checkOutput("t3_pc", pc_o, 6);

    // Bus timeout (TIMEOUT = 4) on an unacked load
    resetCore();
    imem[0] = 16'h8300;
    imem[1] = 16'h6C00;
    imem[2] = 16'h8007;
    imem[3] = 16'h0003;
    releaseReset();
    stepCycle(3);
    checkOutput("t4_cyc_w0", cyc_o, 1);
    checkOutput("t4_adr", adr_o, 32'h300);
    stepCycle(3);
    checkOutput("t4_cyc_w3", cyc_o, 1);
    checkOutput("t4_buserr_w3", bus_err_o, 0);
    stepCycle(1);
    checkOutput("t4_cyc_drop", cyc_o, 0);
    checkOutput("t4_buserr", bus_err_o, 1);
    checkOutput("t4_T_zero", dut.r_t, 0);
    checkOutput("t4_pc", pc_o, 2);
    stepCycle(1);
    checkOutput("t4_continue_T", dut.r_t, 7);
    checkOutput("t4_buserr_sticky", bus_err_o, 1);

    // Data-stack overflow on the 33rd push
    resetCore();
    for (int i = 0; i <= 32; i++) imem[i] = 16'h8000 | 16'(i);
    imem[33] = 16'h0021;
    releaseReset();
    stepCycle(32);
    checkOutput("t5_depth32", dut.u_dstack.r_count, 32);
    checkOutput("t5_nofault", fault_o, 0);
    stepCycle(1);
    checkOutput("t5_fault", fault_o, 2'b01);
    checkOutput("t5_halted", halted_o, 1);
    checkOutput("t5_pc_frozen", pc_o, 32);
    checkOutput("t5_depth_kept", dut.u_dstack.r_count, 32);
    stepCycle(3);
    checkOutput("t5_pc_still", pc_o, 32);
    checkOutput("t5_halted_still", halted_o, 1);
    resetCore();
    checkOutput("t5_rst_fault", fault_o, 0);
    checkOutput("t5_rst_halted", halted_o, 0);

    // CALL / return through R->PC
    imem[0]     = 16'h4010;
    imem[1]     = 16'h0001;
    imem[16'h10] = 16'h700C;
    releaseReset();
    stepCycle(1);
    checkOutput("t6_call_pc", pc_o, 16'h10);
    checkOutput("t6_rsp1", dut.u_rstack.r_count, 1);
    stepCycle(1);
    checkOutput("t6_ret_pc", pc_o, 1);
    checkOutput("t6_rsp0", dut.u_rstack.r_count, 0);

    // halt_i raised mid-MEM only takes effect after the ack
    resetCore();
    imem[0] = 16'h8300;
    imem[1] = 16'h6C00;
    imem[2] = 16'h8009;
    imem[3] = 16'h0003;
    releaseReset();
    stepCycle(2);
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h00);
    stepCycle(1);
    checkOutput("t6_mem_halted", halted_o, 0);
    checkOutput("t6_mem_cyc", cyc_o, 1);
    applyStimulus(1'b1, 1'b1, 32'h55, 8'h00);
    stepCycle(1);
    applyStimulus(1'b1, 1'b0, 32'h0, 8'h00);
    checkOutput("t6_ack_T", dut.r_t, 32'h55);
    checkOutput("t6_ack_pc", pc_o, 2);
    checkOutput("t6_ack_halted", halted_o, 0);
    stepCycle(1);
    checkOutput("t6_halted", halted_o, 1);
    checkOutput("t6_halt_pc", pc_o, 2);
    applyStimulus(1'b0, 1'b0, 32'h0, 8'h00);
    stepCycle(1);
    checkOutput("t6_resume", halted_o, 0);
    stepCycle(1);
    checkOutput("t6_resume_T", dut.r_t, 9);
    checkOutput("t6_resume_pc", pc_o, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
